// File: rtl/int_div_rem_signed_frontend.sv
// Signed/unsigned DIV/REM adapter around an unsigned iterative divider.
// Optional macro DIV_FASTPATH_EN: divide-by-zero requests bypass the divider.
module int_div_rem_signed_frontend #(
    parameter int nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [1:0]         req_op,
    input  logic [nbits-1:0]   req_a,
    input  logic [nbits-1:0]   req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [nbits-1:0]   resp_msg,
    output logic               div_req_val,
    input  logic               div_req_rdy,
    output logic [2*nbits-1:0] div_req_msg,
    input  logic               div_resp_val,
    output logic               div_resp_rdy,
    input  logic [2*nbits-1:0] div_resp_msg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [nbits-1:0] ALL_ONES = {nbits{1'b1}};
    localparam logic [nbits-1:0] ALL_ZERO = {nbits{1'b0}};

    function automatic logic [nbits-1:0] neg(input logic [nbits-1:0] v);
        return ~v + {{(nbits-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r, state_next_s;
    logic [1:0]         op_r;
    logic [nbits-1:0]   a_orig_r, mag_a_r, mag_b_r, result_r;
    logic               sa_r, sb_r, bzero_r;
    logic               req_rdy_r, resp_val_r, div_req_val_r, div_resp_rdy_r;

    logic               sa_in_s, sb_in_s, bzero_in_s, sq_s;
    logic               capture_s, load_res_s;
    logic [nbits-1:0]   q_raw_s, r_raw_s, fix_q_s, fix_r_s, res_next_s;

    assign sa_in_s    = ~req_op[0] & req_a[nbits-1];
    assign sb_in_s    = ~req_op[0] & req_b[nbits-1];
    assign bzero_in_s = (req_b == ALL_ZERO);

    // Sign fix-up of the divider response; divide-by-zero results are forced.
    assign q_raw_s = div_resp_msg[2*nbits-1:nbits];
    assign r_raw_s = div_resp_msg[nbits-1:0];
    assign sq_s    = (sa_r ^ sb_r) & ~bzero_r;
    assign fix_q_s = bzero_r ? ALL_ONES : (sq_s ? neg(q_raw_s) : q_raw_s);
    assign fix_r_s = bzero_r ? a_orig_r : (sa_r ? neg(r_raw_s) : r_raw_s);

    // Next-state, capture and result-load decode.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        load_res_s   = 1'b0;
        res_next_s   = result_r;
        case (state_r)
            S_IDLE: begin
                if (req_val) begin
                    capture_s = 1'b1;
`ifdef DIV_FASTPATH_EN
                    if (bzero_in_s) begin
                        state_next_s = S_RESP;
                        load_res_s   = 1'b1;
                        res_next_s   = req_op[1] ? req_a : ALL_ONES;
                    end else begin
                        state_next_s = S_ISSUE;
                    end
`else
                    state_next_s = S_ISSUE;
`endif
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (div_req_rdy) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (div_resp_val) begin
                    state_next_s = S_RESP;
                    load_res_s   = 1'b1;
                    res_next_s   = op_r[1] ? fix_r_s : fix_q_s;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (resp_rdy) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, registered handshake outputs and operand/result fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= S_IDLE;
            req_rdy_r       <= 1'b1;
            resp_val_r      <= 1'b0;
            div_req_val_r   <= 1'b0;
            div_resp_rdy_r  <= 1'b0;
            op_r            <= 2'd0;
            a_orig_r        <= ALL_ZERO;
            sa_r            <= 1'b0;
            sb_r            <= 1'b0;
            mag_a_r         <= ALL_ZERO;
            mag_b_r         <= ALL_ZERO;
            bzero_r         <= 1'b0;
            result_r        <= ALL_ZERO;
        end else begin
            state_r         <= state_next_s;
            req_rdy_r       <= (state_next_s == S_IDLE);
            resp_val_r      <= (state_next_s == S_RESP);
            div_req_val_r   <= (state_next_s == S_ISSUE);
            div_resp_rdy_r  <= (state_next_s == S_WAIT);
            if (capture_s) begin
                op_r     <= req_op;
                a_orig_r <= req_a;
                sa_r     <= sa_in_s;
                sb_r     <= sb_in_s;
                mag_a_r  <= sa_in_s ? neg(req_a) : req_a;
                mag_b_r  <= sb_in_s ? neg(req_b) : req_b;
                bzero_r  <= bzero_in_s;
            end
            if (load_res_s) begin
                result_r <= res_next_s;
            end
        end
    end

    assign req_rdy      = req_rdy_r;
    assign resp_val     = resp_val_r;
    assign resp_msg     = result_r;
    assign div_req_val  = div_req_val_r;
    assign div_resp_rdy = div_resp_rdy_r;
    assign div_req_msg  = {mag_b_r, mag_a_r};

endmodule

// File: tb/tb_int_div_rem_signed_frontend.sv
// Scoreboard bench for int_div_rem_signed_frontend with a behavioural divider.
module tb_int_div_rem_signed_frontend;
    localparam int N = 32;
    localparam int DIV_LAT = 5;
`ifdef DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_val, req_rdy;
    logic [1:0]     req_op;
    logic [N-1:0]   req_a, req_b;
    logic           resp_val, resp_rdy;
    logic [N-1:0]   resp_msg;
    logic           div_req_val, div_req_rdy;
    logic [2*N-1:0] div_req_msg;
    logic           div_resp_val, div_resp_rdy;
    logic [2*N-1:0] div_resp_msg;

    always #5 clk = ~clk;

    int_div_rem_signed_frontend #(.nbits(N)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .div_req_val(div_req_val), .div_req_rdy(div_req_rdy), .div_req_msg(div_req_msg),
        .div_resp_val(div_resp_val), .div_resp_rdy(div_resp_rdy), .div_resp_msg(div_resp_msg)
    );

    int checks = 0;
    int errors = 0;
    int resp_count = 0;
    int req_stall = 0;
    logic [N-1:0]   exp_q[$];
    logic [2*N-1:0] exp_div_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every accepted response is compared against the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (!reset && resp_val && resp_rdy) begin
            resp_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=%h required=none", resp_msg);
            end else begin
                chk("resp_msg", 64'(resp_msg), 64'(exp_q.pop_front()));
            end
        end
    end

    // Behavioural unsigned divider; outputs change on negedge only.
    initial begin
        int mst;
        int cnt;
        logic [N-1:0] mq, mr, da, db;
        mst = 0; cnt = 0; mq = '0; mr = '0;
        div_req_rdy = 1'b0; div_resp_val = 1'b0; div_resp_msg = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mst = 0;
                div_req_rdy = 1'b0;
                div_resp_val = 1'b0;
            end else begin
                case (mst)
                    0: begin
                        div_resp_val = 1'b0;
                        if (div_req_val && req_stall > 0) begin
                            div_req_rdy = 1'b0;
                            req_stall--;
                        end else begin
                            div_req_rdy = 1'b1;
                        end
                        if (div_req_val && div_req_rdy) begin
                            if (exp_div_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_div_req actual=%h required=none", div_req_msg);
                            end else begin
                                chk("div_req_msg", div_req_msg, exp_div_q.pop_front());
                            end
                            db = div_req_msg[2*N-1:N];
                            da = div_req_msg[N-1:0];
                            if (db == '0) begin
                                mq = '1;
                                mr = da;
                            end else begin
                                mq = da / db;
                                mr = da % db;
                            end
                            cnt = DIV_LAT;
                            mst = 1;
                        end
                    end
                    1: begin
                        div_req_rdy = 1'b0;
                        if (cnt > 1) begin
                            cnt--;
                        end else begin
                            div_resp_val = 1'b1;
                            div_resp_msg = {mq, mr};
                            mst = 2;
                        end
                    end
                    default: ;
                endcase
                if (div_resp_val && div_resp_rdy) mst = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!req_rdy && n < 200) begin
            tick();
            n++;
        end
        if (!req_rdy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp, input logic [2*N-1:0] divmsg);
        wait_idle("issue");
        req_val = 1'b1; req_op = op; req_a = a; req_b = b;
        exp_q.push_back(exp);
        if (!(FAST && b == '0)) exp_div_q.push_back(divmsg);
        tick();
        req_val = 1'b0;
    endtask

    task automatic run(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] exp, input logic [2*N-1:0] divmsg);
        issue(op, a, b, exp, divmsg);
        wait_idle("run");
    endtask

    initial begin
        int n;
        int issue_cycles;
        int rc0;
        reset = 1'b1; req_val = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0; resp_rdy = 1'b1;
        repeat (3) tick();
        chk("rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_div_req_val", 64'(div_req_val), 64'd0);
        chk("rst_div_resp_rdy", 64'(div_resp_rdy), 64'd0);
        chk("rst_resp_msg", 64'(resp_msg), 64'd0);
        reset = 1'b0;
        tick();

        run(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, {32'h00000002, 32'h00000007});
        run(OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, {32'h00000002, 32'h00000007});
        run(OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, {32'h00000002, 32'h00000007});
        run(OP_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, {32'h00000002, 32'h00000007});
        run(OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, {32'h00000010, 32'hFFFFFFFF});
        run(OP_REMU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, {32'h00000010, 32'hFFFFFFFF});
        run(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, {32'h00000001, 32'h80000000});
        run(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, {32'h00000001, 32'h80000000});
        run(OP_REMU, 32'h00000064, 32'h00000007, 32'h00000002, {32'h00000007, 32'h00000064});

        // Divide by zero, including the accept-cycle view of the fast path.
        issue(OP_DIV, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, {32'h00000000, 32'h00000005});
        if (FAST) begin
            chk("dz_fast_resp_val", 64'(resp_val), 64'd1);
            chk("dz_fast_div_req_val", 64'(div_req_val), 64'd0);
        end else begin
            chk("dz_div_req_val", 64'(div_req_val), 64'd1);
            chk("dz_resp_val", 64'(resp_val), 64'd0);
        end
        wait_idle("dz");
        run(OP_REM,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, {32'h00000000, 32'h00000005});
        run(OP_DIVU, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, {32'h00000000, 32'h00001234});

        // Backpressure on both the divider request and the result.
        req_stall = 3;
        resp_rdy = 1'b0;
        rc0 = resp_count;
        issue(OP_DIVU, 32'd100, 32'd7, 32'h0000000E, {32'h00000007, 32'h00000064});
        issue_cycles = 0;
        n = 0;
        while (!resp_val && n < 200) begin
            chk("bp_req_rdy", 64'(req_rdy), 64'd0);
            if (div_req_val) begin
                issue_cycles++;
                chk("bp_div_req_msg", div_req_msg, {32'h00000007, 32'h00000064});
            end
            tick();
            n++;
        end
        chk("bp_resp_seen", 64'(resp_val), 64'd1);
        chk("bp_issue_cycles", 64'(issue_cycles), 64'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_val", 64'(resp_val), 64'd1);
            chk("bp_hold_msg", 64'(resp_msg), 64'h0000000E);
            chk("bp_hold_req_rdy", 64'(req_rdy), 64'd0);
            tick();
        end
        resp_rdy = 1'b1;
        wait_idle("bp");
        repeat (3) tick();
        chk("bp_resp_count", 64'(resp_count - rc0), 64'd1);

        // Reset while waiting on the divider discards the operation.
        issue(OP_DIVU, 32'd50, 32'd5, 32'd10, {32'h00000005, 32'h00000032});
        n = 0;
        while (!div_resp_rdy && n < 200) begin
            tick();
            n++;
        end
        chk("mid_wait_reached", 64'(div_resp_rdy), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("mid_rst_resp_val", 64'(resp_val), 64'd0);
        chk("mid_rst_div_req_val", 64'(div_req_val), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        exp_div_q.delete();
        tick();
        run(OP_DIV, 32'd9, 32'd3, 32'd3, {32'h00000003, 32'h00000009});

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/int_div_rem_signed_frontend.md
Name: int_div_rem_signed_frontend

Overview:
- Request/response adapter placed around the unsigned iterative divider.
- Upstream, it accepts RISC-V-style DIV/DIVU/REM/REMU requests and converts signed operands to magnitudes. It then issues an unsigned {divisor, dividend} request to the divider.
- Downstream, it consumes the divider's {quotient, remainder} response, applies sign correction and divide-by-zero rules, and returns the single selected result.
- Pure control-plus-fixup stage; the divider itself is a separate instance wired to the div_* ports.

Parameters:
- nbits, 32, operand/result width (even, >= 4; must match the divider's nbits)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_val  in  1  upstream request valid
- req_rdy  out  1  upstream request ready
- req_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- req_a  in  nbits  dividend
- req_b  in  nbits  divisor
- resp_val  out  1  result valid
- resp_rdy  in  1  result ready
- resp_msg  out  nbits  selected result
- div_req_val  out  1  to divider req_val
- div_req_rdy  in  1  from divider req_rdy
- div_req_msg  out  2*nbits  [2n-1:n]=divisor magnitude, [n-1:0]=dividend magnitude
- div_resp_val  in  1  from divider resp_val
- div_resp_rdy  out  1  to divider resp_rdy
- div_resp_msg  in  2*nbits  [2n-1:n]=quotient, [n-1:0]=remainder

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, req_rdy=1, resp_val=0, div_req_val=0, div_resp_rdy=0, resp_msg=0.
- Registered fields:
  - op
  - a_orig
  - sa = signed op & a[n-1]
  - sb = signed op & b[n-1]
  - mag_a = sa ? -a : a
  - mag_b = sb ? -b : b
  - bzero = (b==0)
  - result
- Magnitude negation is nbits two's complement. -(most-negative) = most-negative, which reads correctly as unsigned 2^(n-1).
- FSM (one-hot-free encoded, 4 states):
  - IDLE: req_rdy=1. Transfer on req_val&req_rdy: capture fields, go to ISSUE.
  - ISSUE: div_req_val=1 and div_req_msg={mag_b, mag_a}, both driven from registers and stable while waiting. On div_req_rdy, go to WAIT.
  - WAIT: div_resp_rdy=1. On div_resp_val, compute the fixed-up result into the result register and go to RESP.
  - RESP: resp_val=1 and resp_msg=result, held stable until resp_rdy. On transfer, go to IDLE.
- Fix-up (combinational on div_resp_msg, registered on capture):
  - sq = (sa^sb) & ~bzero
  - sr = sa
  - q = sq ? -Q : Q
  - r = sr ? -R : R
  - DIV/DIVU return q; REM/REMU return r.
- Divide-by-zero results: q = all ones for both signed and unsigned (divider yields all ones, sq is forced 0); r = a_orig.
- Overflow (DIV most-negative / -1): q = most-negative, r = 0. This falls out of the magnitude path; no special case is needed.
- Only one operation is in flight at a time. req_rdy=0 in all states except IDLE, so there is no simultaneous accept and respond.
- Latency, accept to resp_val (divider path): 1 (ISSUE) + divider latency + 1 capture cycle. Zero-stall minimum = nbits/2 + 4 cycles.
- Reset mid-operation: the FSM returns to IDLE next edge and the in-flight result is discarded. The divider shares reset and must also be reset by the integrator.
- div_resp_val outside WAIT is ignored (protocol error, not flagged).

Optional Feature:
- DIV_FASTPATH_EN, defined: when IDLE accepts a request with bzero=1, the FSM goes directly to RESP. The result is loaded in the accept cycle using the divide-by-zero rules, and div_req_val is never asserted. resp_val rises 1 cycle after accept.
- DIV_FASTPATH_EN undefined: every request goes through the divider with identical results and full latency.

Test Plan (nbits=32):
- DIV a=0xFFFFFFF9 (-7), b=2 -> resp_msg=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; div_req_msg={0x00000002,0x00000007}.
- DIVU a=0xFFFFFFFF, b=0x10 -> 0x0FFFFFFF; REMU same -> 0x0000000F.
- DIV a=0xFFFFFFFB (-5), b=0 -> 0xFFFFFFFF; REM -> 0xFFFFFFFB. With DIV_FASTPATH_EN: resp_val the cycle after accept and div_req_val stays 0.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
- Backpressure: DIVU 100/7 with div_req_rdy low 3 cycles and resp_rdy low 5 cycles. div_req_msg and resp_msg (0x0000000E) stay stable, req_rdy=0 throughout, exactly one response.
- Reset asserted in WAIT -> next cycle req_rdy=1, resp_val=0, div_req_val=0. A following DIV 9/3 returns 3.
